// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared definitions for the SHA-256 block controller.
//   state_t     : controller FSM states
//   BLOCK_BYTES : bytes per compression block
//   LEN_POS     : byte index where the 64-bit bit-length field starts
//   PAD_BYTE    : first padding byte (the single '1' bit marker)
package sha256_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_POS     = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    LEN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// sha256_block_ctrl_if -- byte-stream input and compression-core handshake.
//   in_data/in_valid/in_last/in_ready : message byte stream
//   core_start/core_first/core_final/core_block/core_done : core launch/complete
//   msg_done : whole-message digest ready, len_err : sticky length overflow
// master = environment (byte source + core), slave = the controller.
interface sha256_block_ctrl_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         core_start;
  logic         core_first;
  logic         core_final;
  logic [511:0] core_block;
  logic         core_done;
  logic         msg_done;
  logic         len_err;

  modport master (
    output in_data, in_valid, in_last, core_done,
    input  in_ready, core_start, core_first, core_final, core_block, msg_done, len_err
  );

  modport slave (
    input  in_data, in_valid, in_last, core_done,
    output in_ready, core_start, core_first, core_final, core_block, msg_done, len_err
  );
endinterface

// File: rtl/sha256_pad_buffer.sv
// sha256_pad_buffer -- 64-byte block buffer, byte 0 at block[511:504].
//   clr              : zero whole buffer (highest priority)
//   len_wr/len_bits  : write 64-bit big-endian length into bytes 56..63
//   wr_en/wr_idx/wr_byte : single byte write
//   block            : buffer contents
module sha256_pad_buffer
  import sha256_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [5:0]               wr_idx,
  input  logic [7:0]               wr_byte,
  input  logic                     len_wr,
  input  logic [63:0]              len_bits,
  output logic [BLOCK_BYTES*8-1:0] block
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      block <= '0;
    else if (clr)
      block <= '0;
    else if (len_wr)
      block[(BLOCK_BYTES-LEN_POS)*8-1:0] <= len_bits;
    else if (wr_en)
      // byte i lives at bit offset (63-i)*8, and 63-i == ~i for a 6-bit index
      block[{~wr_idx, 3'b000} +: 8] <= wr_byte;
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl -- splits a byte stream into padded SHA-256 blocks and
// sequences the compression core.
//   clk, reset (async, active-high)
//   bus   : sha256_block_ctrl_if.slave (byte stream in, core handshake out)
//   abort : only when SHA_CTRL_ABORT_EN is defined; drops the current message
// LEN_W : byte-length counter width (1..61), saturates and flags len_err.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic clk,
  input  logic reset,
`ifdef SHA_CTRL_ABORT_EN
  input  logic abort,
`endif
  sha256_block_ctrl_if.slave bus
);

  state_t           state;
  logic [6:0]       idx;          // 0..64, 64 means block full during PAD
  logic [LEN_W-1:0] total_len;
  logic             first_flag;
  logic             final_flag;
  logic             pad_pend;     // 0x80 marker not yet written
  logic             pad_active;   // message ended, remaining blocks are padding
  logic             abort_pend;   // abort seen while core busy
  logic             in_ready, core_start, core_first, core_final, msg_done, len_err;
  logic [511:0]     blk;

  logic             abort_req;
`ifdef SHA_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  logic        accept, early_abort, pad_wr, buf_clr, len_wr;
  logic [7:0]  wr_byte;
  logic [63:0] len_bits;

  assign accept      = bus.in_valid && in_ready && !abort_req;
  assign early_abort = abort_req && (state inside {IDLE, LOAD, PAD, LEN});
  // PAD writes a byte unless it is about to issue (full) or hand over to LEN
  assign pad_wr      = (state == PAD) && !abort_req && (idx != 7'(BLOCK_BYTES))
                       && !(idx == 7'(LEN_POS) && !pad_pend);
  assign len_wr      = (state == LEN) && !abort_req;
  assign buf_clr     = (state == DONE) || early_abort
                       || (state == WAIT && bus.core_done && (abort_pend || abort_req));
  assign wr_byte     = (state == PAD) ? (pad_pend ? PAD_BYTE : 8'h00) : bus.in_data;
  assign len_bits    = 64'(total_len) << 3;

  sha256_pad_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .wr_en    (accept || pad_wr),
    .wr_idx   (idx[5:0]),
    .wr_byte  (wr_byte),
    .len_wr   (len_wr),
    .len_bits (len_bits),
    .block    (blk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      total_len  <= '0;
      first_flag <= 1'b0;
      final_flag <= 1'b0;
      pad_pend   <= 1'b0;
      pad_active <= 1'b0;
      abort_pend <= 1'b0;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      core_first <= 1'b0;
      core_final <= 1'b0;
      msg_done   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      msg_done   <= 1'b0;
      in_ready   <= 1'b0;   // re-raised by every path landing in IDLE/LOAD

      if (accept) begin
        idx <= idx + 7'd1;
        if (&total_len) len_err   <= 1'b1;
        else            total_len <= total_len + LEN_W'(1);
      end

      if (early_abort) begin
        state      <= IDLE;
        idx        <= '0;
        total_len  <= '0;
        first_flag <= 1'b0;
        pad_pend   <= 1'b0;
        pad_active <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (accept && state == IDLE) first_flag <= 1'b1;
            if (accept && bus.in_last) begin
              state      <= PAD;
              pad_pend   <= 1'b1;
              pad_active <= 1'b1;
            end else if (accept && idx == 7'(BLOCK_BYTES-1)) begin
              state      <= ISSUE;
              final_flag <= 1'b0;
            end else begin
              in_ready <= 1'b1;
              if (accept) state <= LOAD;
            end
          end
          PAD: begin
            if (idx == 7'(BLOCK_BYTES)) begin
              state      <= ISSUE;
              final_flag <= 1'b0;
            end else if (idx == 7'(LEN_POS) && !pad_pend) begin
              state <= LEN;
            end else begin
              idx      <= idx + 7'd1;
              pad_pend <= 1'b0;
            end
          end
          LEN: begin
            state      <= ISSUE;
            final_flag <= 1'b1;
          end
          ISSUE: begin
            if (abort_req) abort_pend <= 1'b1;
            core_start <= 1'b1;
            core_first <= first_flag;
            core_final <= final_flag;
            state      <= WAIT;
          end
          WAIT: begin
            if (abort_req) abort_pend <= 1'b1;
            if (bus.core_done) begin
              idx        <= '0;
              first_flag <= 1'b0;
              if (abort_pend || abort_req) begin
                state      <= IDLE;
                abort_pend <= 1'b0;
                total_len  <= '0;
                pad_pend   <= 1'b0;
                pad_active <= 1'b0;
                in_ready   <= 1'b1;
              end else if (final_flag) begin
                state <= DONE;
              end else if (pad_active) begin
                state <= PAD;
              end else begin
                state    <= LOAD;
                in_ready <= 1'b1;
              end
            end
          end
          DONE: begin
            msg_done   <= 1'b1;
            total_len  <= '0;
            pad_active <= 1'b0;
            state      <= IDLE;
            in_ready   <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.core_start = core_start;
  assign bus.core_first = core_first;
  assign bus.core_final = core_final;
  assign bus.core_block = blk;
  assign bus.msg_done   = msg_done;
  assign bus.len_err    = len_err;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl -- scoreboard bench for sha256_block_ctrl.
// Expected blocks come from a byte-level padding model; a monitor pops and
// compares on core_start / msg_done. Abort test needs SHA_CTRL_ABORT_EN.
module tb_sha256_block_ctrl;
  localparam int LW     = 8;
  localparam int MAXLEN = (1 << LW) - 1;

  typedef struct {
    logic [511:0] blk;
    bit           first;
    bit           fin;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef SHA_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  sha256_block_ctrl_if bus();

  sha256_block_ctrl #(.LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SHA_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  exp_t       exp_q[$];
  int         msg_q[$];
  logic [7:0] cur[$];
  int         msg_id = 0;
  bit         core_auto = 1'b1;
  int         done_req = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: message, 0x80, zeros to 56 mod 64, 64-bit BE bit length.
  task automatic expect_msg(input bit want_done);
    logic [7:0]  p[$];
    logic [63:0] bits;
    exp_t        e;
    int          n, len, nb;
    n = cur.size();
    p = cur;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len  = (n > MAXLEN) ? MAXLEN : n;
    bits = 64'(len) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = p[64*b+j];
      e.first = (b == 0);
      e.fin   = (b == nb - 1);
      exp_q.push_back(e);
    end
    msg_id++;
    if (want_done) msg_q.push_back(msg_id);
  endtask

  task automatic new_msg(input int n);
    cur.delete();
    for (int k = 0; k < n; k++) cur.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input int n, input bit with_last);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        continue;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = cur[i];
      bus.in_last  = with_last && (i == n - 1);
      if (bus.in_ready) i++;   // in_ready only changes on posedge
    end
    check("bytes_accepted", i, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || msg_q.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_left", exp_q.size() + msg_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",   bus.in_ready,   0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_core_first", bus.core_first, 0);
    check("rst_core_final", bus.core_final, 0);
    check("rst_core_block", bus.core_block, 0);
    check("rst_msg_done",   bus.msg_done,   0);
    check("rst_len_err",    bus.len_err,    0);
  endtask

  // Compression core model: done after a random delay, or on request.
  initial begin
    int cnt;
    int ack;
    cnt = 0;
    ack = 0;
    bus.core_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (reset) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.core_done = 1'b1;
      end else if (core_auto && bus.core_start) cnt = $urandom_range(1, 6);
      if (done_req != ack) begin
        ack = done_req;
        bus.core_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e, lat;
    bit   busy, ok;
    int   id;
    busy = 1'b0;
    ok   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset) busy = 1'b0;
      else begin
        if (busy) begin
          if (bus.core_done) begin
            check("hold_in_wait", ok, 1);
            busy = 1'b0;
          end else if (bus.core_block !== lat.blk || bus.core_first !== lat.first ||
                       bus.core_final !== lat.fin || bus.in_ready !== 1'b0)
            ok = 1'b0;
        end
        if (bus.core_start) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: got core_start=1 want 0");
          end else begin
            e = exp_q.pop_front();
            check("block", bus.core_block, e.blk);
            check("first", bus.core_first, e.first);
            check("final", bus.core_final, e.fin);
          end
          lat.blk   = bus.core_block;
          lat.first = bus.core_first;
          lat.fin   = bus.core_final;
          busy = 1'b1;
          ok   = 1'b1;
        end
        if (bus.msg_done) begin
          if (msg_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_msg_done: got msg_done=1 want 0");
          end else begin
            id = msg_q.pop_front();
            check("blocks_before_done", exp_q.size(), 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);

    // "abc"
    cur = '{8'h61, 8'h62, 8'h63};
    expect_msg(1'b1);
    drive(3, 1'b1);
    wait_drain();

    // boundary lengths: one block, two blocks, full data block
    new_msg(55); expect_msg(1'b1); drive(55, 1'b1); wait_drain();
    new_msg(56); expect_msg(1'b1); drive(56, 1'b1); wait_drain();
    new_msg(64); expect_msg(1'b1); drive(64, 1'b1); wait_drain();
    new_msg(1);  expect_msg(1'b1); drive(1, 1'b1);  wait_drain();

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 200);
      new_msg(n);
      expect_msg(1'b1);
      drive(n, 1'b1);
      wait_drain();
    end
    check("len_err_clear", bus.len_err, 0);

    // reset while the core is busy; late core_done must be ignored
    core_auto = 1'b0;
    cur = '{8'h61, 8'h62, 8'h63};
    expect_msg(1'b0);
    drive(3, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst2", bus.in_ready, 1);
    done_req++;
    repeat (20) @(negedge clk);
    core_auto = 1'b1;
    cur = '{8'h61, 8'h62, 8'h63};
    expect_msg(1'b1);
    drive(3, 1'b1);
    wait_drain();

`ifdef SHA_CTRL_ABORT_EN
    // abort after 10 bytes, with a byte offered in the same cycle
    new_msg(11);
    drive(10, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = cur[10];
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_to_idle", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    new_msg(3);
    expect_msg(1'b1);
    drive(3, 1'b1);
    wait_drain();
`endif

    // length counter overflow: 256 bytes into an 8-bit counter
    new_msg(256);
    expect_msg(1'b1);
    drive(256, 1'b1);
    wait_drain();
    check("len_err_set", bus.len_err, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("len_err_rst", bus.len_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
